// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: fetch FSM states, well-known instruction words,
// and the IF/ID bundle that decode consumes.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INS  = 32'hE1A0_0000;
    localparam logic [31:0] HALT_INS = 32'hEF00_0000;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; flush beats load, otherwise holds. Registered, 1 cycle.
// No backpressure of its own: the caller withholds load to stall.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INS = cpu_pkg::NOP_INS
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '{ins: NOP_INS, pc: 32'd0, valid: 1'b0};
        end else if (flush) begin
            q <= '{ins: NOP_INS, pc: 32'd0, valid: 1'b0};
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, redirect, halt/fault FSM; ROM word registered into IF/ID, 1-cycle latency.
// Stall holds PC and IF/ID; a branch overrides stall; HALT ignores both until reset.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 6,
    parameter logic [31:0] NOP_INS  = cpu_pkg::NOP_INS,
    parameter logic [31:0] HALT_INS = cpu_pkg::HALT_INS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [ROM_AW-1:0] ins_addr,
    input  logic [31:0]       ins,
    output logic [31:0]       if_id_ins,
    output logic [31:0]       if_id_pc,
    output logic              if_id_valid,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       fetch_count
);

    localparam logic [32:0] ROM_BYTES = 33'(1) << (ROM_AW + 2);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [32:0]  pc_plus4;
    logic         end_of_rom;
    logic         br_bad;
    logic         ifid_load, ifid_flush;
    if_id_t       ifid_d, ifid_q;
    logic         cnt_inc, fault_set;

    // Computed one bit wider so the end-of-ROM compare never sees a wrapped PC.
    assign pc_plus4   = {1'b0, pc} + 33'd4;
    assign end_of_rom = (pc_plus4 >= ROM_BYTES);
    assign br_bad     = (branch_target[1:0] != 2'b00) || ({1'b0, branch_target} >= ROM_BYTES);
    assign ins_addr   = pc[ROM_AW+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
                if (branch_taken) begin
                    if (br_bad) state_nxt = HALT;
                end else if (!stall && ((ins == HALT_INS) || end_of_rom)) begin
                    state_nxt = HALT;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_nxt     = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_d     = '{ins: ins, pc: pc, valid: 1'b1};
        cnt_inc    = 1'b0;
        fault_set  = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush = 1'b1;
                    if (br_bad) fault_set = 1'b1;
                    else        pc_nxt    = branch_target;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    cnt_inc   = 1'b1;
                    // A halt word parks the PC on itself; the last ROM word faults instead of wrapping.
                    if (ins != HALT_INS) begin
                        if (end_of_rom) fault_set = 1'b1;
                        else            pc_nxt    = pc_plus4[31:0];
                    end
                end
            end
            HALT: begin
                ifid_load = 1'b1;
                ifid_d    = '{ins: ifid_q.ins, pc: ifid_q.pc, valid: 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            fetch_count <= 16'd0;
            fault       <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (cnt_inc && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
            if (fault_set) fault <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP_INS (NOP_INS)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign if_id_ins   = ifid_q.ins;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_valid = ifid_q.valid;
    assign halted      = (state == HALT);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the single-issue ARM pipeline. Sits directly upstream of the 64x32 instruction ROM and drives its 6-bit word address.
- The ROM returns the word combinationally in the same cycle. This block registers that word into the IF/ID pipeline register for decode.
- Holds the PC, applies stall and branch redirect from later stages, and halts on a halt instruction or when the PC runs out of ROM range.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
ROM_AW, 6, ROM word-address width; ROM span is 4*2^ROM_AW bytes
NOP_INS, 32'hE1A0_0000, bubble word (MOV r0,r0) loaded into IF/ID on reset or flush
HALT_INS, 32'hEF00_0000, SWI 0; fetching it halts the fetch stage

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID (hazard unit)
branch_taken  in  1  redirect request from execute
branch_target  in  32  byte address of redirect target
ins_addr  out  ROM_AW  word address to ROM, equal to pc[ROM_AW+1:2]
ins  in  32  instruction word from ROM, combinational on ins_addr
if_id_ins  out  32  registered instruction to decode
if_id_pc  out  32  byte PC of if_id_ins
if_id_valid  out  1  if_id_ins is a real instruction
halted  out  1  fetch has stopped; sticky until rst
fault  out  1  halt was caused by an out-of-range PC or a misaligned target; sticky
fetch_count  out  16  number of valid IF/ID captures; saturates at 16'hFFFF

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=IDLE
  - if_id_ins=NOP_INS, if_id_pc=0, if_id_valid=0
  - halted=0, fault=0, fetch_count=0
- State IDLE: lasts exactly one cycle after rst deasserts. No capture, PC unchanged. Next state is RUN.
- State RUN, evaluated each rising edge in this priority order:
  1. branch_taken=1:
     - pc<=branch_target
     - IF/ID <= {NOP_INS, 0, valid=0}
     - This overrides stall and suppresses halt detection on the current word.
     - If branch_target[1:0]!=0 or branch_target>=4*2^ROM_AW: go to HALT with fault=1 and pc unchanged.
  2. stall=1: pc, IF/ID and fetch_count are all held.
  3. ins==HALT_INS:
     - IF/ID captures {ins, pc, valid=1} and fetch_count increments, so decode still sees the SWI.
     - Next state is HALT with fault=0.
  4. Otherwise:
     - IF/ID <= {ins, pc, 1}; fetch_count+=1 (saturating); pc<=pc+4.
     - If pc+4>=4*2^ROM_AW: pc is held at its current value, and next state is HALT with fault=1. The current word is still delivered.
- State HALT:
  - pc is frozen.
  - IF/ID holds its last value for one cycle, then if_id_valid<=0.
  - halted=1. stall and branch_taken are ignored.
  - Exit only through rst.
- ins_addr is always pc[ROM_AW+1:2] and is purely combinational from the pc register. Fetch latency is 1 cycle from PC to if_id_ins.
- PC wrap-around is never allowed. Reaching the end of the ROM is a fault, not a wrap to 0.
- Asserting reset in the middle of a stall, a branch or a HALT returns every output to its reset value in the same instant.

Decomposition:
- Shared package `cpu_pkg`:
  - fetch state enum {IDLE, RUN, HALT}
  - NOP_INS and HALT_INS constants
  - an IF/ID bundle struct {ins, pc, valid} reused by decode
- One sub-module: `if_id_reg`, the IF/ID pipeline register with load, flush and hold controls.
- The PC, next-PC logic and FSM stay in fetch_stage.

Test Plan:
- Straight-line code: ROM[0..3]=distinct words, no stall or branch. After IDLE, if_id_pc = 0, 4, 8, 12 on consecutive cycles with valid=1; fetch_count=4 after 4 captures.
- Stall: stall=1 for 3 cycles while pc=8. ins_addr stays 2, IF/ID and fetch_count are unchanged, and fetch resumes at pc=8.
- Branch with simultaneous stall: branch_taken=1, branch_target=0x40, stall=1. Next cycle pc=0x40, if_id_valid=0, if_id_ins=NOP_INS; the cycle after, if_id_pc=0x40.
- Halt instruction: ROM[5]=HALT_INS. if_id_ins=0xEF000000 with valid=1; then halted=1, fault=0, and pc is frozen at 0x14.
- Faults:
  - Running off the ROM end: last word at pc=0xFC is delivered, then halted=1, fault=1.
  - branch_target=0x102 gives halted=1, fault=1.
- Reset mid-run: rst pulsed while in HALT or mid-stall. All outputs return to reset values immediately, then fetch restarts at RESET_PC after one IDLE cycle.
